seven_seg_scan_driver: RTL
==========================

// Module: seven_seg_scan_driver
// PURPOSE
//   Time-multiplexed driver for an N-digit common-anode seven-segment display.
//   Latches a packed digit vector plus decimal points and scans one digit per refresh slot.
//   Decodes each digit in BCD or hex, suppresses leading zeros, and inserts anti-ghost blanking.
//   Sits between the stopwatch counter/formatting logic and the board display pins.
// PARAMETERS
//   NUM_DIGITS      4       digits scanned, legal 1..8
//   REFRESH_DIV     100000  clk cycles per digit slot, >=2
//   BLANK_CYCLES    16      cycles at start of each slot with all anodes off, < REFRESH_DIV
//   HEX_MODE        0       0: codes 10-15 render blank; 1: codes render A,b,C,d,E,F
//   LZ_SUPPRESS     1       1: enable leading-zero blanking
//   SEG_ACTIVE_LOW  1       1: seg/dp driven low = lit; 0: inverted
//   AN_ACTIVE_LOW   1       1: an driven low = digit on; 0: inverted
// PORTS
//   clk        in   1              system clock
//   reset      in   1              synchronous, active-high
//   en         in   1              scan enable; low = display dark, scan frozen
//   load       in   1              capture digits/dp_in into shadow register
//   digits     in   4*NUM_DIGITS   digit i at [4i+3:4i]; i=0 least significant
//   dp_in      in   NUM_DIGITS     decimal point per digit
//   seg        out  7              segments {g,f,e,d,c,b,a}, registered
//   dp         out  1              decimal point of active digit, registered
//   an         out  NUM_DIGITS     anode enables, one-hot when active, registered
//   frame_tick out  1              1-cycle pulse when scan wraps to digit 0
// BEHAVIOUR
// - Clock clk only; reset is synchronous and active-high and overrides all else.
// - Reset: presc=0, idx=0, shadow=0; an, seg, dp all inactive level; frame_tick=0.
// - Shadow: on load=1 (not in reset) shadow <= {digits, dp_in} at that edge; otherwise holds.
// - Prescaler: if en, presc counts 0..REFRESH_DIV-1 then wraps to 0; if !en, presc and idx hold.
// - Index: on en && presc==REFRESH_DIV-1, idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1.
// - frame_tick asserted the cycle after en && presc==REFRESH_DIV-1 && idx==NUM_DIGITS-1.
// - Output registers: values at edge t+1 computed from presc/idx/shadow at cycle t (1-cycle latency).
// - an: bit idx active iff en && presc>=BLANK_CYCLES; all other bits inactive.
// - seg active-low patterns (a=bit0): 0=1000000 1=1111001 2=0100100 3=0110000
//   4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000
//   HEX_MODE=1: A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110.
//   HEX_MODE=0, code>9: blank 1111111. SEG_ACTIVE_LOW=0 inverts seg and dp.
// - Leading zeros (LZ_SUPPRESS=1): digit i>0 blanked (seg and dp off) iff digit i and all
//   digits above are 0 and none of dp bits i..NUM_DIGITS-1 are set. Digit 0 never suppressed.
// - dp output = shadow dp bit idx unless digit is suppressed; off whenever an is all inactive.
// - en deasserted mid-slot: next edge an all inactive, seg/dp blank; resume continues same slot.
// - load during an active slot: new value visible on seg no later than 2 edges after load.
// - Reset mid-scan: next edge returns everything to reset state; scan restarts at digit 0.
// - NUM_DIGITS=1: idx stays 0; frame_tick pulses every REFRESH_DIV cycles.
// TESTING (NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, active-low unless noted)
// - Reset held 3 cycles -> an=1111, seg=1111111, dp=1, frame_tick=0; release, en=1 -> an goes
//   1110 two edges after release, then 1111/1110 pattern per slot (1 blank, 3 lit).
// - load digits=16'h1234, dp_in=0100 -> slot0 seg=0011001 (4), slot1 seg=0110000 dp=1,
//   slot2 seg=0100100 dp=0, slot3 seg=1111001; frame_tick every 16 cycles, with idx->0.
// - digits=16'h0007, dp=0000, LZ on -> slots1-3 seg=1111111 with an lit; slot0 seg=1111000;
//   digits=16'h0000 -> slot0 shows 0 (1000000); dp_in=0100 -> slot2 shows 0, slot3 blank.
// - HEX_MODE=0 digits=16'hABCD -> all slots blank; HEX_MODE=1 -> d,C,b,A patterns per above.
// - en=0 for 10 cycles mid-slot2 -> an=1111, seg blank, frame_tick=0; en=1 -> slot2 resumes,
//   remaining cycles of slot preserved.
// - Reset asserted during slot3 with load=1 same cycle -> shadow=0, idx=0, outputs inactive.

Source files
------------

// File: rtl/seven_seg_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_driver_if
//   Bundles the display-driver data path: the digit/decimal-point load side
//   coming from the stopwatch formatting logic and the registered pin side
//   going to the board.
//
//   master : producer of en/load/digits/dp_in, consumer of the display pins
//   slave  : the scan driver itself
//
//   en         scan enable (low = display dark, scan frozen)
//   load       capture digits/dp_in into the driver's shadow register
//   digits     digit i at [4i+3:4i], i=0 least significant
//   dp_in      decimal point per digit
//   seg        segments {g,f,e,d,c,b,a}
//   dp         decimal point of the active digit
//   an         anode enables, one-hot when a digit is lit
//   frame_tick one-cycle pulse when the scan wraps to digit 0
// -----------------------------------------------------------------------------
interface seven_seg_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      en;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   digits;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic [6:0]                seg;
    logic                      dp;
    logic [NUM_DIGITS-1:0]     an;
    logic                      frame_tick;

    modport master (
        output en, load, digits, dp_in,
        input  seg, dp, an, frame_tick
    );

    modport slave (
        input  en, load, digits, dp_in,
        output seg, dp, an, frame_tick
    );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_driver
//   Time-multiplexed driver for an N-digit common-anode seven-segment display.
//   A shadow register holds the digit vector and decimal points; one digit is
//   shown per refresh slot. Each slot opens with BLANK_CYCLES of all anodes
//   off to stop the previous digit ghosting onto the next one. Digits decode
//   as BCD (codes 10-15 blank) or hex, and leading zeros can be suppressed.
//
//   clk    system clock
//   reset  synchronous, active-high; returns everything to the dark state
//   bus    seven_seg_scan_driver_if.slave (en, load, digits, dp_in in;
//          seg, dp, an, frame_tick out, all outputs registered)
// -----------------------------------------------------------------------------
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 100000,
    parameter int BLANK_CYCLES   = 16,
    parameter bit HEX_MODE       = 1'b0,
    parameter bit LZ_SUPPRESS    = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    seven_seg_scan_driver_if.slave  bus
);

    localparam int PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PRESC_W-1:0]    PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [PRESC_W-1:0]    BLANK_END  = PRESC_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE     = NUM_DIGITS'(1);
    localparam logic [6:0]            SEG_DARK   = 7'b1111111;

    // Active-low glyph for one code; the caller applies pin polarity.
    function automatic logic [6:0] decode_glyph(input logic [3:0] code);
        logic [6:0] g;
        case (code)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            4'd10:   g = HEX_MODE ? 7'b0001000 : SEG_DARK;
            4'd11:   g = HEX_MODE ? 7'b0000011 : SEG_DARK;
            4'd12:   g = HEX_MODE ? 7'b1000110 : SEG_DARK;
            4'd13:   g = HEX_MODE ? 7'b0100001 : SEG_DARK;
            4'd14:   g = HEX_MODE ? 7'b0000110 : SEG_DARK;
            default: g = HEX_MODE ? 7'b0001110 : SEG_DARK;
        endcase
        return g;
    endfunction

    // Internally everything is active-low; these map to the pin polarity.
    function automatic logic [6:0] seg_pins(input logic [6:0] seg_low);
        return SEG_ACTIVE_LOW ? seg_low : ~seg_low;
    endfunction

    function automatic logic dp_pin(input logic dp_low);
        return SEG_ACTIVE_LOW ? dp_low : ~dp_low;
    endfunction

    function automatic logic [NUM_DIGITS-1:0] an_pins(input logic [NUM_DIGITS-1:0] an_low);
        return AN_ACTIVE_LOW ? an_low : ~an_low;
    endfunction

    logic [PRESC_W-1:0]      presc;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] shadow_dig;
    logic [NUM_DIGITS-1:0]   shadow_dp;

    logic [6:0]              seg_p1;
    logic                    dp_p1;
    logic [NUM_DIGITS-1:0]   an_p1;
    logic                    tick_p1;

    logic                    slot_end;
    logic                    lit;
    logic                    show;
    logic                    upper_nz;
    logic [NUM_DIGITS-1:0]   supp;
    logic [3:0]              cur_code;
    logic                    cur_dp;
    logic [6:0]              seg_low;
    logic                    dp_low;
    logic [NUM_DIGITS-1:0]   an_low;

    // Leading-zero mask: walk from the top digit down; a digit stays
    // suppressible only while every digit and dp from it upward is clear.
    always_comb begin
        upper_nz = 1'b0;
        supp     = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_nz = upper_nz | (shadow_dig[4*i +: 4] != 4'd0) | shadow_dp[i];
            supp[i]  = LZ_SUPPRESS && (i != 0) && !upper_nz;
        end
    end

    always_comb begin
        slot_end = bus.en && (presc == PRESC_LAST);
        lit      = bus.en && (presc >= BLANK_END);
        cur_code = shadow_dig[{idx, 2'b00} +: 4];
        cur_dp   = shadow_dp[idx];
        show     = lit && !supp[idx];
        seg_low  = show ? decode_glyph(cur_code) : SEG_DARK;
        dp_low   = !(show && cur_dp);
        an_low   = lit ? ~(AN_ONE << idx) : '1;
    end

    // Stage p0: scan position and shadow register
    always_ff @(posedge clk) begin
        if (reset) begin
            presc      <= '0;
            idx        <= '0;
            shadow_dig <= '0;
            shadow_dp  <= '0;
        end else begin
            if (bus.load) begin
                shadow_dig <= bus.digits;
                shadow_dp  <= bus.dp_in;
            end
            if (bus.en) begin
                presc <= slot_end ? '0 : presc + 1'b1;
                if (slot_end) begin
                    idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                end
            end
        end
    end

    // Stage p1: registered display pins, one cycle behind presc/idx/shadow
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_p1  <= seg_pins(SEG_DARK);
            dp_p1   <= dp_pin(1'b1);
            an_p1   <= an_pins('1);
            tick_p1 <= 1'b0;
        end else begin
            seg_p1  <= seg_pins(seg_low);
            dp_p1   <= dp_pin(dp_low);
            an_p1   <= an_pins(an_low);
            tick_p1 <= slot_end && (idx == IDX_LAST);
        end
    end

    assign bus.seg        = seg_p1;
    assign bus.dp         = dp_p1;
    assign bus.an         = an_p1;
    assign bus.frame_tick = tick_p1;

endmodule
